eth_tx_arbiter: RTL
===================

Name: eth_tx_arbiter

Overview:
- Frame-granular arbiter sharing the single 64-bit AXI-stream transmit path toward the 10G MAC among three reply generators: port 0 = ARP reply, port 1 = ICMP echo reply, port 2 = UDP transmit.
- Once a source is granted, it holds the path until its tlast beat is accepted.
- A stall watchdog aborts a granted source that stops supplying beats mid-frame.
- Per-port frame and abort counters are exported for status registers.

Parameters:
- STALL_LIMIT, 256: consecutive mid-frame cycles with granted tvalid=0 that trigger an abort; legal range 2..65535.
- CNT_W, 16: width of the frame and abort counters.
- ARP_PRIORITY, 0: 1 = port 0 wins any arbitration in which it requests; 0 = pure round-robin.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_sN_tvalid  in  1  source N (N=0..2) beat valid
- i_sN_tdata  in  64  source N data
- i_sN_tkeep  in  8  source N byte enables
- i_sN_tlast  in  1  source N last beat of frame
- o_sN_tready  out  3 x 1  ready back to source N
- o_m_tvalid  out  1  beat valid to MAC
- o_m_tdata  out  64  data to MAC
- o_m_tkeep  out  8  byte enables to MAC
- o_m_tlast  out  1  last beat to MAC
- o_m_tuser  out  1  1 = frame error, MAC discards frame
- i_m_tready  in  1  MAC ready
- o_grant  out  3  one-hot current grant; 0 when idle
- o_busy  out  1  1 in any state other than IDLE
- o_frame_cnt_N  out  3 x CNT_W  completed frames per port
- o_abort_cnt  out  CNT_W  total aborts

Behaviour:
- Reset (synchronous, i_reset=1 at a clock edge) forces:
  - state = IDLE; o_grant=0; all counters 0; last_grant=port 2, so the first round-robin pick is port 0.
  - Outputs to 0: o_m_tvalid, o_m_tdata, o_m_tkeep, o_m_tlast, o_m_tuser, every o_sN_tready, o_busy.
  - Reset mid-frame drops the frame silently; no tlast is emitted.
- IDLE:
  - All o_sN_tready=0; o_m_tvalid=0.
  - Arbitration samples the current cycle's i_sN_tvalid.
  - Round-robin search order is last_grant+1, +2, +3 (mod 3).
  - With ARP_PRIORITY=1 and i_s0_tvalid=1, port 0 wins regardless of order.
  - Grant is registered. Request in cycle t gives o_grant and XFER in cycle t+1; the first beat can transfer in t+1.
  - No request: stay in IDLE.
- XFER (granted port g):
  - Combinational passthrough: o_m_tvalid=i_sg_tvalid; o_m_tdata, o_m_tkeep and o_m_tlast come from port g; o_m_tuser=0.
  - o_sg_tready=i_m_tready; other ports' tready=0.
  - A beat transfers when o_m_tvalid & i_m_tready.
  - Transfer with tlast=1: frame_cnt_g +1 (wraps at 2^CNT_W), last_grant=g, next state IDLE. This gives a mandatory one-cycle gap between frames.
  - Stall counter: +1 each cycle i_sg_tvalid=0; cleared when i_sg_tvalid=1. MAC backpressure (tvalid=1, tready=0) does not count.
  - Stall counter reaching STALL_LIMIT: next state ABORT; the counter clears.
- ABORT:
  - Emits one beat: o_m_tvalid=1, tdata=0, tkeep=8'h01, tlast=1, tuser=1.
  - All o_sN_tready=0.
  - Held until i_m_tready=1. On acceptance: abort_cnt +1 (wraps), next state DRAIN.
  - frame_cnt is not incremented.
- DRAIN:
  - o_m_tvalid=0; o_sg_tready=1 so the remainder of port g's frame is discarded.
  - Accepted beat with tlast=1: last_grant=g, next state IDLE.
  - No watchdog runs in DRAIN.
- o_busy=1 in XFER, ABORT and DRAIN.
- o_grant stays valid through ABORT and DRAIN.
- Requests on non-granted ports wait; no beats are lost on them since their tready=0.
- A frame whose first beat carries tlast (single-beat frame) completes in the same cycle it transfers.

Test Plan:
- All three sources each present a 3-beat frame at cycle 0 → grants in order 0,1,2; each grant starts 1 cycle after the previous tlast; o_frame_cnt_0/1/2 = 1/1/1.
- Port 2 holds a continuous request while port 1 requests once, last_grant=2 → port 1 wins the next arbitration, then port 2; port 2 is never starved across 10 frames.
- ARP_PRIORITY=1, ports 0 and 2 request while last_grant=2 → port 0 granted. With ARP_PRIORITY=0 the same stimulus also gives port 0; repeat with last_grant=0 → port 2 in RR mode, port 0 in priority mode.
- Port 1 frame with i_m_tready toggling 1010 for 6 beats → MAC receives the exact tdata/tkeep sequence unchanged, the tlast beat carries tkeep=8'h0F, and o_abort_cnt stays 0.
- STALL_LIMIT=4; port 2 sends 2 beats then tvalid=0 for 4 cycles → beat {tdata=0, tkeep=8'h01, tlast=1, tuser=1}, o_abort_cnt=1; port 2's remaining 3 beats are drained with nothing on the MAC; frame_cnt_2 unchanged.
- i_reset=1 for one cycle in the middle of a port 0 frame → next cycle every output is 0 and o_grant=0; the following request from port 1 and port 0 together is granted to port 0.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// ============================================================================
// eth_tx_arbiter : frame-granular 3:1 AXI-stream arbiter for the 10G MAC TX path
//                  (ARP / ICMP / UDP sources) with a mid-frame stall watchdog.
// Revision 1.0   : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module eth_tx_arbiter #(
   parameter int STALL_LIMIT  = 256,
   parameter int CNT_W        = 16,
   parameter int ARP_PRIORITY = 0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_s0_tvalid,
   input  logic [63:0]      i_s0_tdata,
   input  logic [7:0]       i_s0_tkeep,
   input  logic             i_s0_tlast,
   output logic             o_s0_tready,
   input  logic             i_s1_tvalid,
   input  logic [63:0]      i_s1_tdata,
   input  logic [7:0]       i_s1_tkeep,
   input  logic             i_s1_tlast,
   output logic             o_s1_tready,
   input  logic             i_s2_tvalid,
   input  logic [63:0]      i_s2_tdata,
   input  logic [7:0]       i_s2_tkeep,
   input  logic             i_s2_tlast,
   output logic             o_s2_tready,
   output logic             o_m_tvalid,
   output logic [63:0]      o_m_tdata,
   output logic [7:0]       o_m_tkeep,
   output logic             o_m_tlast,
   output logic             o_m_tuser,
   input  logic             i_m_tready,
   output logic [2:0]       o_grant,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_frame_cnt_0,
   output logic [CNT_W-1:0] o_frame_cnt_1,
   output logic [CNT_W-1:0] o_frame_cnt_2,
   output logic [CNT_W-1:0] o_abort_cnt
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_XFER  = 2'd1;
   localparam logic [1:0] S_ABORT = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   localparam logic [15:0]      STALL_LAST = 16'(STALL_LIMIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic [1:0]       state;
   logic [2:0]       grant;
   logic [1:0]       gsel;
   logic [1:0]       last_grant;
   logic [15:0]      stall_cnt;
   logic [CNT_W-1:0] frame_cnt [3];
   logic [CNT_W-1:0] abort_cnt;

   logic [2:0]       req;
   logic [1:0]       cand1;
   logic [1:0]       cand2;
   logic [1:0]       pick;
   logic             pick_vld;

   logic             sel_tvalid;
   logic [63:0]      sel_tdata;
   logic [7:0]       sel_tkeep;
   logic             sel_tlast;
   logic [2:0]       src_ready;

   function automatic logic [1:0] rr_next(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   assign req = {i_s2_tvalid, i_s1_tvalid, i_s0_tvalid};

   // Round-robin search starts one past the last owner; ARP may pre-empt it.
   always_comb begin
      cand1    = rr_next(last_grant);
      cand2    = rr_next(cand1);
      pick     = 2'd0;
      pick_vld = 1'b1;
      if (ARP_PRIORITY != 0 && req[0]) begin
         pick = 2'd0;
      end else if (req[cand1]) begin
         pick = cand1;
      end else if (req[cand2]) begin
         pick = cand2;
      end else if (req[last_grant]) begin
         pick = last_grant;
      end else begin
         pick_vld = 1'b0;
      end
   end

   always_comb begin
      sel_tvalid = 1'b0;
      sel_tdata  = 64'd0;
      sel_tkeep  = 8'd0;
      sel_tlast  = 1'b0;
      case (gsel)
         2'd0: begin
            sel_tvalid = i_s0_tvalid;
            sel_tdata  = i_s0_tdata;
            sel_tkeep  = i_s0_tkeep;
            sel_tlast  = i_s0_tlast;
         end
         2'd1: begin
            sel_tvalid = i_s1_tvalid;
            sel_tdata  = i_s1_tdata;
            sel_tkeep  = i_s1_tkeep;
            sel_tlast  = i_s1_tlast;
         end
         2'd2: begin
            sel_tvalid = i_s2_tvalid;
            sel_tdata  = i_s2_tdata;
            sel_tkeep  = i_s2_tkeep;
            sel_tlast  = i_s2_tlast;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      o_m_tvalid = 1'b0;
      o_m_tdata  = 64'd0;
      o_m_tkeep  = 8'd0;
      o_m_tlast  = 1'b0;
      o_m_tuser  = 1'b0;
      src_ready  = 3'b000;
      case (state)
         S_XFER: begin
            o_m_tvalid      = sel_tvalid;
            o_m_tdata       = sel_tdata;
            o_m_tkeep       = sel_tkeep;
            o_m_tlast       = sel_tlast;
            src_ready[gsel] = i_m_tready;
         end
         S_ABORT: begin
            // Error-marked terminator so the MAC discards the truncated frame.
            o_m_tvalid = 1'b1;
            o_m_tkeep  = 8'h01;
            o_m_tlast  = 1'b1;
            o_m_tuser  = 1'b1;
         end
         S_DRAIN: begin
            src_ready[gsel] = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state        <= S_IDLE;
         grant        <= 3'b000;
         gsel         <= 2'd0;
         last_grant   <= 2'd2;
         stall_cnt    <= 16'd0;
         frame_cnt[0] <= '0;
         frame_cnt[1] <= '0;
         frame_cnt[2] <= '0;
         abort_cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               stall_cnt <= 16'd0;
               if (pick_vld) begin
                  grant <= 3'b001 << pick;
                  gsel  <= pick;
                  state <= S_XFER;
               end
            end
            S_XFER: begin
               if (sel_tvalid && i_m_tready && sel_tlast) begin
                  frame_cnt[gsel] <= frame_cnt[gsel] + CNT_ONE;
                  last_grant      <= gsel;
                  grant           <= 3'b000;
                  stall_cnt       <= 16'd0;
                  state           <= S_IDLE;
               end else if (!sel_tvalid) begin
                  if (stall_cnt == STALL_LAST) begin
                     stall_cnt <= 16'd0;
                     state     <= S_ABORT;
                  end else begin
                     stall_cnt <= stall_cnt + 16'd1;
                  end
               end else begin
                  stall_cnt <= 16'd0;
               end
            end
            S_ABORT: begin
               if (i_m_tready) begin
                  abort_cnt <= abort_cnt + CNT_ONE;
                  state     <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (sel_tvalid && sel_tlast) begin
                  last_grant <= gsel;
                  grant      <= 3'b000;
                  state      <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_s0_tready   = src_ready[0];
   assign o_s1_tready   = src_ready[1];
   assign o_s2_tready   = src_ready[2];
   assign o_grant       = grant;
   assign o_busy        = (state != S_IDLE);
   assign o_frame_cnt_0 = frame_cnt[0];
   assign o_frame_cnt_1 = frame_cnt[1];
   assign o_frame_cnt_2 = frame_cnt[2];
   assign o_abort_cnt   = abort_cnt;

endmodule

`default_nettype wire
